// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: memory request/response ports toward boot ROM and
// instruction memory, plus the instruction stream toward decode.
interface instr_fetch_if;
  logic [15:0] mem_addr;
  logic        rom_req;
  logic        rom_ack;
  logic [31:0] rom_data;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [15:0] instr_pc;
  logic        instr_ready;

  modport master (
    output mem_addr, rom_req, imem_req, instr_valid, instr_data, instr_pc,
    input  rom_ack, rom_data, imem_ack, imem_data, instr_ready
  );

  modport slave (
    input  mem_addr, rom_req, imem_req, instr_valid, instr_data, instr_pc,
    output rom_ack, rom_data, imem_ack, imem_data, instr_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: one-outstanding requests to boot ROM or imem, a 2-entry
// instruction FIFO toward decode, and branch redirects that drop in-flight data.
module instr_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          boot_mode,
  input  logic          instr_mem_over,
  input  logic          branch_en,
  input  logic [15:0]   branch_pc,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  state_t      state, state_next;
  logic [15:0] pc, pc_next;
  logic [15:0] addr, addr_next;
  logic        src_rom, src_rom_next;

  logic [31:0] fifo_data [2];
  logic [15:0] fifo_pc   [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count, count_next;

  logic        ack;
  logic [31:0] ack_data;
  logic        push, pop;
  logic        issue_ok, issue;

  // Only the port that was latched at issue time can complete a request.
  assign ack      = (state != IDLE) && (src_rom ? bus.rom_ack : bus.imem_ack);
  assign ack_data = src_rom ? bus.rom_data : bus.imem_data;

  assign pop        = (count != 2'd0) && bus.instr_ready;
  assign push       = (state == WAIT) && ack && !branch_en;
  assign count_next = branch_en ? 2'd0 : (count + {1'b0, push} - {1'b0, pop});
  assign issue_ok   = (count_next < 2'd2) && (boot_mode || !instr_mem_over);

  always_comb begin
    state_next   = state;
    pc_next      = pc;
    addr_next    = addr;
    src_rom_next = src_rom;
    issue        = 1'b0;
    case (state)
      IDLE: begin
        pc_next = branch_en ? branch_pc : pc;
        issue   = issue_ok;
      end
      WAIT: begin
        if (ack) begin
          pc_next = branch_en ? branch_pc : pc + 16'd1;
          issue   = issue_ok;
          if (!issue_ok) state_next = IDLE;
        end else if (branch_en) begin
          pc_next    = branch_pc;
          state_next = DISCARD;
        end
      end
      DISCARD: begin
        pc_next = branch_en ? branch_pc : pc;
        if (ack) begin
          issue = issue_ok;
          if (!issue_ok) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (issue) begin
      state_next   = WAIT;
      addr_next    = pc_next;
      src_rom_next = boot_mode;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      addr    <= RESET_PC;
      src_rom <= 1'b0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      addr    <= addr_next;
      src_rom <= src_rom_next;
    end
  end

  // A redirect empties the FIFO outright; pushes and pops that edge are void.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= 32'd0;
        fifo_pc[i]   <= 16'd0;
      end
    end else if (branch_en) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= ack_data;
        fifo_pc[wr_ptr]   <= pc;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count_next;
    end
  end

  assign bus.rom_req     = (state != IDLE) && src_rom;
  assign bus.imem_req    = (state != IDLE) && !src_rom;
  assign bus.mem_addr    = addr;
  assign bus.instr_valid = (count != 2'd0);
  assign bus.instr_data  = fifo_data[rd_ptr];
  assign bus.instr_pc    = fifo_pc[rd_ptr];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with wait-state-configurable ROM/imem
// responders whose data encodes the requested address.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        boot_mode;
  logic        instr_mem_over;
  logic        branch_en;
  logic [15:0] branch_pc;

  int checks = 0;
  int errors = 0;

  int rom_wait  = 0;
  int imem_wait = 0;
  logic rom_force  = 1'b0;
  logic imem_force = 1'b0;
  int rom_cnt  = 0;
  int imem_cnt = 0;
  logic rom_ack_model, imem_ack_model;

  instr_fetch_if bus ();

  instr_fetch #(.RESET_PC(16'h0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .boot_mode      (boot_mode),
    .instr_mem_over (instr_mem_over),
    .branch_en      (branch_en),
    .branch_pc      (branch_pc),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  // Memory responders: ack once the request has been held for *_wait edges.
  assign rom_ack_model  = bus.rom_req  && (rom_cnt  >= rom_wait);
  assign imem_ack_model = bus.imem_req && (imem_cnt >= imem_wait);
  assign bus.rom_ack    = rom_ack_model  | rom_force;
  assign bus.imem_ack   = imem_ack_model | imem_force;
  assign bus.rom_data   = {16'hB000, bus.mem_addr};
  assign bus.imem_data  = {16'hA000, bus.mem_addr};

  always @(posedge clk) begin
    rom_cnt  <= (!bus.rom_req  || rom_ack_model)  ? 0 : rom_cnt + 1;
    imem_cnt <= (!bus.imem_req || imem_ack_model) ? 0 : imem_cnt + 1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset(input logic bm, input logic imo, input logic rdy);
    rst = 1'b1;
    boot_mode = bm;
    instr_mem_over = imo;
    bus.instr_ready = rdy;
    branch_en = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    boot_mode = 1'b1;
    instr_mem_over = 1'b0;
    branch_en = 1'b0;
    branch_pc = 16'h0000;
    bus.instr_ready = 1'b1;
    tick();
    tick();
    check_output("reset_rom_req",   {31'd0, bus.rom_req},     32'd0);
    check_output("reset_imem_req",  {31'd0, bus.imem_req},    32'd0);
    check_output("reset_mem_addr",  {16'd0, bus.mem_addr},    32'h0000);
    check_output("reset_valid",     {31'd0, bus.instr_valid}, 32'd0);
    check_output("reset_data",      bus.instr_data,           32'd0);
    check_output("reset_pc",        {16'd0, bus.instr_pc},    32'd0);

    $display("[TB] zero-wait ROM streaming");
    rst = 1'b0;
    tick();
    check_output("rom_first_req",  {31'd0, bus.rom_req},     32'd1);
    check_output("rom_first_addr", {16'd0, bus.mem_addr},    32'h0000);
    check_output("rom_first_nv",   {31'd0, bus.instr_valid}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_output("rom_stream_valid", {31'd0, bus.instr_valid}, 32'd1);
      check_output("rom_stream_pc",    {16'd0, bus.instr_pc},    i);
      check_output("rom_stream_data",  bus.instr_data,           32'hB0000000 + i);
      check_output("rom_stream_addr",  {16'd0, bus.mem_addr},    i + 1);
      check_output("rom_stream_imem",  {31'd0, bus.imem_req},    32'd0);
    end

    $display("[TB] imem backpressure");
    apply_reset(1'b0, 1'b0, 1'b0);
    tick();
    check_output("bp_req0",  {31'd0, bus.imem_req}, 32'd1);
    check_output("bp_rom0",  {31'd0, bus.rom_req},  32'd0);
    tick();
    check_output("bp_addr1", {16'd0, bus.mem_addr}, 32'h0001);
    check_output("bp_pc0",   {16'd0, bus.instr_pc}, 32'h0000);
    tick();
    check_output("bp_req_drop", {31'd0, bus.imem_req},    32'd0);
    check_output("bp_full_v",   {31'd0, bus.instr_valid}, 32'd1);
    tick();
    check_output("bp_still_idle", {31'd0, bus.imem_req},  32'd0);
    check_output("bp_head_pc0",   {16'd0, bus.instr_pc},  32'h0000);
    bus.instr_ready = 1'b1;
    tick();
    check_output("bp_pop_pc1",    {16'd0, bus.instr_pc},  32'h0001);
    check_output("bp_resume_req", {31'd0, bus.imem_req},  32'd1);
    check_output("bp_resume_addr",{16'd0, bus.mem_addr},  32'h0002);
    tick();
    check_output("bp_pc2",   {16'd0, bus.instr_pc}, 32'h0002);
    check_output("bp_data2", bus.instr_data,        32'hA0000002);
    check_output("bp_addr3", {16'd0, bus.mem_addr}, 32'h0003);

    $display("[TB] branch during slow imem request");
    imem_wait = 3;
    apply_reset(1'b0, 1'b0, 1'b1);
    tick();
    check_output("br_req",  {31'd0, bus.imem_req}, 32'd1);
    branch_en = 1'b1;
    branch_pc = 16'h0040;
    tick();
    branch_en = 1'b0;
    check_output("br_disc_req",  {31'd0, bus.imem_req},    32'd1);
    check_output("br_disc_addr", {16'd0, bus.mem_addr},    32'h0000);
    check_output("br_disc_nv",   {31'd0, bus.instr_valid}, 32'd0);
    tick();
    tick();
    check_output("br_pre_ack_nv", {31'd0, bus.instr_valid}, 32'd0);
    tick();
    check_output("br_dropped_nv", {31'd0, bus.instr_valid}, 32'd0);
    check_output("br_new_addr",   {16'd0, bus.mem_addr},    32'h0040);
    check_output("br_new_req",    {31'd0, bus.imem_req},    32'd1);
    imem_wait = 0;
    tick();
    check_output("br_first_v",    {31'd0, bus.instr_valid}, 32'd1);
    check_output("br_first_pc",   {16'd0, bus.instr_pc},    32'h0040);
    check_output("br_first_data", bus.instr_data,           32'hA0000040);

    $display("[TB] branch coincident with ack, and branch with full FIFO");
    rom_wait = 0;
    apply_reset(1'b1, 1'b0, 1'b0);
    tick();
    tick();
    check_output("bc_count1_v", {31'd0, bus.instr_valid}, 32'd1);
    branch_en = 1'b1;
    branch_pc = 16'h0100;
    tick();
    branch_en = 1'b0;
    check_output("bc_flush_nv", {31'd0, bus.instr_valid}, 32'd0);
    check_output("bc_req",      {31'd0, bus.rom_req},     32'd1);
    check_output("bc_addr",     {16'd0, bus.mem_addr},    32'h0100);
    tick();
    check_output("bc_pc",   {16'd0, bus.instr_pc}, 32'h0100);
    check_output("bc_data", bus.instr_data,        32'hB0000100);
    tick();
    check_output("bf_idle", {31'd0, bus.rom_req}, 32'd0);
    branch_en = 1'b1;
    branch_pc = 16'h0200;
    tick();
    branch_en = 1'b0;
    check_output("bf_flush_nv", {31'd0, bus.instr_valid}, 32'd0);
    check_output("bf_req",      {31'd0, bus.rom_req},     32'd1);
    check_output("bf_addr",     {16'd0, bus.mem_addr},    32'h0200);

    $display("[TB] source switching");
    imem_wait = 3;
    apply_reset(1'b0, 1'b1, 1'b1);
    tick();
    check_output("sw_over_imem", {31'd0, bus.imem_req}, 32'd0);
    tick();
    check_output("sw_over_imem2", {31'd0, bus.imem_req}, 32'd0);
    check_output("sw_over_rom",   {31'd0, bus.rom_req},  32'd0);
    instr_mem_over = 1'b0;
    tick();
    check_output("sw_imem_req", {31'd0, bus.imem_req}, 32'd1);
    boot_mode = 1'b1;
    tick();
    check_output("sw_keep_imem", {31'd0, bus.imem_req}, 32'd1);
    check_output("sw_no_rom",    {31'd0, bus.rom_req},  32'd0);
    rom_force = 1'b1;
    tick();
    rom_force = 1'b0;
    check_output("sw_foreign_ack_nv", {31'd0, bus.instr_valid}, 32'd0);
    check_output("sw_foreign_req",    {31'd0, bus.imem_req},    32'd1);
    tick();
    check_output("sw_wait_nv", {31'd0, bus.instr_valid}, 32'd0);
    tick();
    check_output("sw_imem_pc",   {16'd0, bus.instr_pc},  32'h0000);
    check_output("sw_imem_data", bus.instr_data,         32'hA0000000);
    check_output("sw_rom_req",   {31'd0, bus.rom_req},   32'd1);
    check_output("sw_imem_off",  {31'd0, bus.imem_req},  32'd0);
    check_output("sw_rom_addr",  {16'd0, bus.mem_addr},  32'h0001);
    tick();
    check_output("sw_rom_pc",   {16'd0, bus.instr_pc}, 32'h0001);
    check_output("sw_rom_data", bus.instr_data,        32'hB0000001);

    $display("[TB] pc wrap and mid-request reset");
    imem_wait = 0;
    rom_wait = 0;
    apply_reset(1'b1, 1'b0, 1'b1);
    tick();
    branch_en = 1'b1;
    branch_pc = 16'hFFFF;
    tick();
    branch_en = 1'b0;
    check_output("wrap_addr", {16'd0, bus.mem_addr},    32'hFFFF);
    check_output("wrap_nv",   {31'd0, bus.instr_valid}, 32'd0);
    tick();
    check_output("wrap_pc",       {16'd0, bus.instr_pc}, 32'hFFFF);
    check_output("wrap_data",     bus.instr_data,        32'hB000FFFF);
    check_output("wrap_next_addr",{16'd0, bus.mem_addr}, 32'h0000);

    rom_wait = 5;
    apply_reset(1'b1, 1'b0, 1'b1);
    tick();
    check_output("mr_req", {31'd0, bus.rom_req}, 32'd1);
    rst = 1'b1;
    tick();
    check_output("mr_rst_req",   {31'd0, bus.rom_req},     32'd0);
    check_output("mr_rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    check_output("mr_rst_addr",  {16'd0, bus.mem_addr},    32'h0000);
    rst = 1'b0;
    rom_force = 1'b1;
    tick();
    rom_force = 1'b0;
    check_output("mr_late_ack_nv", {31'd0, bus.instr_valid}, 32'd0);
    check_output("mr_reissue",     {31'd0, bus.rom_req},     32'd1);
    tick();
    check_output("mr_late_ack_nv2", {31'd0, bus.instr_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
